// File: rtl/fetch_decode_skid_reg_if.sv
// Fetch-to-decode handshake bundle: fetch-side valid/ready/payload plus decode-side valid/ready/payload.
// The pipeline register takes the slave view; the fetch/decode environment takes the master view.
interface fetch_decode_skid_reg_if #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 9
);
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/fetch_decode_skid_reg.sv
// Fetch/decode pipeline register built as a two-entry skid buffer.
// in_ready depends only on state, so there is no combinational path from decode back to fetch.
module fetch_decode_skid_reg #(
  parameter int unsigned        PC_W      = 8,
  parameter int unsigned        INSTR_W   = 9,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     stall,
  fetch_decode_skid_reg_if.slave   bus,
  output logic [1:0]               occupancy
);

  logic               m_valid_q, m_valid_d;
  logic [PC_W-1:0]    m_pc_q, m_pc_d;
  logic [INSTR_W-1:0] m_instr_q, m_instr_d;
  logic               s_valid_q, s_valid_d;
  logic [PC_W-1:0]    s_pc_q, s_pc_d;
  logic [INSTR_W-1:0] s_instr_q, s_instr_d;
  logic               acc, drn;

  assign bus.in_ready  = ~s_valid_q;
  assign bus.out_valid = m_valid_q;
  assign bus.out_pc    = m_pc_q;
  assign bus.out_instr = m_instr_q;
  assign occupancy     = {1'b0, m_valid_q} + {1'b0, s_valid_q};

  assign acc = bus.in_valid & ~s_valid_q & ~flush;
  assign drn = m_valid_q & bus.out_ready & ~stall & ~flush;

  always_comb begin
    m_valid_d = m_valid_q;
    m_pc_d    = m_pc_q;
    m_instr_d = m_instr_q;
    s_valid_d = s_valid_q;
    s_pc_d    = s_pc_q;
    s_instr_d = s_instr_q;

    if (flush) begin
      m_valid_d = 1'b0;
      m_pc_d    = '0;
      m_instr_d = NOP_INSTR;
      s_valid_d = 1'b0;
      s_pc_d    = '0;
      s_instr_d = NOP_INSTR;
    end else if (!m_valid_q || (drn && !s_valid_q)) begin
      // M is empty or drains with no skid entry behind it: load from fetch or show a NOP bubble.
      if (acc) begin
        m_valid_d = 1'b1;
        m_pc_d    = bus.in_pc;
        m_instr_d = bus.in_instr;
      end else begin
        m_valid_d = 1'b0;
        m_pc_d    = '0;
        m_instr_d = NOP_INSTR;
      end
    end else if (!drn) begin
      if (acc) begin
        s_valid_d = 1'b1;
        s_pc_d    = bus.in_pc;
        s_instr_d = bus.in_instr;
      end
    end else begin
      // Drain with S full: S advances into M; acc is impossible since in_ready is low.
      m_valid_d = 1'b1;
      m_pc_d    = s_pc_q;
      m_instr_d = s_instr_q;
      s_valid_d = 1'b0;
      s_pc_d    = '0;
      s_instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_pc_q    <= '0;
      m_instr_q <= NOP_INSTR;
      s_valid_q <= 1'b0;
      s_pc_q    <= '0;
      s_instr_q <= NOP_INSTR;
    end else begin
      m_valid_q <= m_valid_d;
      m_pc_q    <= m_pc_d;
      m_instr_q <= m_instr_d;
      s_valid_q <= s_valid_d;
      s_pc_q    <= s_pc_d;
      s_instr_q <= s_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_decode_skid_reg.sv
// Bench for fetch_decode_skid_reg: directed scenarios plus a random soak, checked every cycle
// against a two-deep FIFO reference model kept as a queue.
module tb_fetch_decode_skid_reg;
  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 9;
  localparam logic [INSTR_W-1:0] NOP = 9'h1F0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic       CLK = 1'b0;
  logic       reset, flush, stall;
  logic [1:0] occupancy;

  fetch_decode_skid_reg_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  fetch_decode_skid_reg #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .flush     (flush),
    .stall     (stall),
    .bus       (bus),
    .occupancy (occupancy)
  );

  always #5 CLK = ~CLK;

  int     pass_cnt = 0;
  int     chk_cnt  = 0;
  entry_t exp_q[$];
  entry_t head;
  int     n;
  bit     do_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the stage is a FIFO of capacity 2, ready whenever it held fewer than 2
  // entries at the start of the cycle; flush empties it and drops the incoming entry.
  always @(negedge CLK) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      n = exp_q.size();
      check("occupancy", {30'd0, occupancy}, n);
      check("in_ready", {31'd0, bus.in_ready}, (n < 2) ? 1 : 0);
      check("out_valid", {31'd0, bus.out_valid}, (n > 0) ? 1 : 0);
      if (n > 0) head = exp_q[0];
      else head = '{pc: '0, instr: NOP};
      check("out_pc", {24'd0, bus.out_pc}, {24'd0, head.pc});
      check("out_instr", {23'd0, bus.out_instr}, {23'd0, head.instr});
      check("s_implies_m", {31'd0, dut.s_valid_q & ~dut.m_valid_q}, 0);
      if (flush) begin
        exp_q.delete();
      end else begin
        do_acc = bus.in_valid && (n < 2);
        if (n > 0 && bus.out_ready && !stall) void'(exp_q.pop_front());
        if (do_acc) exp_q.push_back('{pc: bus.in_pc, instr: bus.in_instr});
      end
    end
  end

  task automatic cyc(input logic iv, input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins,
                     input logic ordy, input logic st, input logic fl);
    @(posedge CLK);
    #1;
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    stall         = st;
    flush         = fl;
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; stall = 1'b0;
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.out_ready = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check("rst_out_instr", {23'd0, bus.out_instr}, {23'd0, NOP});
    check("rst_in_ready", {31'd0, bus.in_ready}, 1);
    repeat (2) @(negedge CLK);
    #2 reset = 1'b0;

    // Streaming, one cycle latency, no bubbles
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h10 + i[7:0], 9'h110 + i[8:0], 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    #1 check("stream_last_pc", {24'd0, bus.out_pc}, 32'h17);
    idle(1'b1);

    // Backpressure fill, then release
    cyc(1'b1, 8'h20, 9'h120, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h21, 9'h121, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 9'h122, 1'b0, 1'b0, 1'b0);
    #1 check("bp_in_ready_low", {31'd0, bus.in_ready}, 0);
    check("bp_head", {24'd0, bus.out_pc}, 32'h20);
    cyc(1'b1, 8'h22, 9'h122, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 9'h122, 1'b1, 1'b0, 1'b0);
    repeat (3) idle(1'b1);

    // Stall holds M while S still fills
    cyc(1'b1, 8'h30, 9'h130, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h31, 9'h131, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    #1 check("stall_hold_pc", {24'd0, bus.out_pc}, 32'h30);
    check("stall_occ", {30'd0, occupancy}, 2);
    repeat (3) idle(1'b1);

    // Flush with full buffer, incoming 0x40 dropped
    cyc(1'b1, 8'h38, 9'h138, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h39, 9'h139, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h40, 9'h140, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    check("flush_out_instr", {23'd0, bus.out_instr}, 32'h1F0);
    check("flush_occ", {30'd0, occupancy}, 0);
    repeat (2) idle(1'b1);

    // Asynchronous reset mid-stream with occupancy 2
    cyc(1'b1, 8'h50, 9'h150, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h51, 9'h151, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 0);
    check("mid_rst_out_pc", {24'd0, bus.out_pc}, 0);
    check("mid_rst_out_instr", {23'd0, bus.out_instr}, {23'd0, NOP});
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 1);
    check("mid_rst_occ", {30'd0, occupancy}, 0);
    @(negedge CLK);
    #2 reset = 1'b0;

    // Random soak
    for (int i = 0; i < 10000; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 9'($urandom), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
    repeat (3) idle(1'b1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_decode_skid_reg.md
Name: fetch_decode_skid_reg

Overview:
- Parametrised successor to the fetch/decode pipeline register.
- Carries a PC and an instruction word from fetch into decode through a two-entry skid buffer with a valid/ready handshake. Upstream ready is therefore a registered signal with no combinational path from downstream ready.
- Supports a global stall, a flush that injects a configurable NOP, and an occupancy output for hazard and debug logic.

Parameters:
- PC_W, 8, width of the PC field.
- INSTR_W, 9, width of the instruction field.
- NOP_INSTR, {INSTR_W{1'b0}}, encoding driven on out_instr when the stage is empty, flushed or reset.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous kill of all held and incoming entries.
- stall  in  1  blocks the downstream transfer; upstream acceptance continues while space remains.
- in_valid  in  1  fetch presents a valid entry.
- in_ready  out  1  stage can accept an entry this cycle; registered.
- in_pc  in  PC_W  PC of the incoming entry.
- in_instr  in  INSTR_W  instruction of the incoming entry.
- out_valid  out  1  decode-side entry valid.
- out_ready  in  1  decode accepts the entry.
- out_pc  out  PC_W  PC of the head entry.
- out_instr  out  INSTR_W  instruction of the head entry.
- occupancy  out  2  number of held entries, 0..2.

Behaviour:
- Storage:
  - Main register M (valid, pc, instr) drives the out_* ports.
  - Skid register S (valid, pc, instr) holds the overflow entry.
- Reset (async, any time including mid-transfer):
  - M.valid = S.valid = 0.
  - out_pc = 0, out_instr = NOP_INSTR, out_valid = 0, in_ready = 1, occupancy = 0.
- Handshake events (each cycle):
  - acc = in_valid & in_ready & !flush.
  - drn = out_valid & out_ready & !stall & !flush.
- in_ready = !S.valid, registered, so it depends only on state.
- out_valid = M.valid.
- occupancy = M.valid + S.valid.
- Transitions when flush = 0:
  - M empty, acc: M <= in. Latency 1 cycle from acceptance to out_valid.
  - M full, !drn, acc: S <= in. in_ready drops next cycle.
  - M full, drn, S empty, acc: M <= in (pass-through, full throughput).
  - M full, drn, S empty, !acc: M becomes empty.
  - M full, drn, S full: M <= S, S empties. acc cannot occur because in_ready = 0.
  - M full, !drn, S full: hold both entries.
- Empty-M data rule: whenever M becomes or stays empty, out_pc <= 0 and out_instr <= NOP_INSTR. Decode therefore always sees a NOP bubble.
- Flush:
  - Next edge clears M.valid and S.valid and forces out_pc = 0, out_instr = NOP_INSTR.
  - Any input presented that cycle is dropped.
  - in_ready = 1 the following cycle.
- Priority: flush > stall > normal.
  - flush with stall clears the stage.
  - stall blocks only the drain. It does not block acceptance into an empty M or into S.
- Ordering: strict FIFO. The entry in S never overtakes M. No entry is lost or duplicated except by flush or reset.
- Invariant: S.valid implies M.valid. Verification asserts this and asserts occupancy never exceeds 2.
- No combinational path from out_ready, stall or flush to in_ready.

Test Plan:
- Reset mid-stream:
  - Stimulus: assert reset while occupancy = 2.
  - Required: immediately out_valid = 0, out_instr = NOP_INSTR, out_pc = 0, in_ready = 1, occupancy = 0.
- Streaming:
  - Stimulus: out_ready = 1, stall = 0, send PC 0x10..0x17 back to back with instr = PC + 9'h100.
  - Required: each entry appears 1 cycle after acceptance, in order, no bubbles, occupancy stays 1.
- Backpressure fill:
  - Stimulus: out_ready = 0, send 0x20, 0x21, 0x22.
  - Required: 0x20 is held in M and 0x21 in S; in_ready = 0 after the second accept; 0x22 stays pending.
  - Stimulus: release out_ready.
  - Required: outputs 0x20, 0x21, 0x22 in order, no loss.
- Stall:
  - Stimulus: stall = 1 with M = 0x30 and out_ready = 1.
  - Required: out_pc holds 0x30 for the whole stall; one further input is accepted into S.
  - Stimulus: deassert stall.
  - Required: 0x30 then the next entry are output.
- Flush with full buffer:
  - Stimulus: occupancy = 2 and in_valid = 1 with PC 0x40, then flush for 1 cycle.
  - Required: next cycle out_valid = 0, out_instr = NOP_INSTR, occupancy = 0, 0x40 never appears; with NOP_INSTR = 9'h1F0, out_instr = 9'h1F0.
- Random soak:
  - Stimulus: 10k cycles of random in_valid, out_ready, stall, and flush at 2%.
  - Required: scoreboard shows order preserved and the S-implies-M invariant is never violated.
